// File: rtl/abs_sample_collector.sv
// Collects signed per-channel samples and keeps their saturated 15-bit
// magnitudes on a packed bus. It also watches enabled channels for stale updates.
module abs_sample_collector #(
    parameter int NUM_CH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      channel_enable,
    input  logic [15:0]            stale_limit,
    input  logic [15:0]            sample_tdata,
    input  logic [2:0]             sample_tchannel,
    input  logic                   sample_tvalid,
    output logic                   sample_tready,
    output logic [NUM_CH*15-1:0]   abs_sample_concat,
    output logic                   sample_core_done,
    output logic                   err_stale,
    output logic                   err_config,
    output logic [2:0]             stale_channel
);

    typedef enum logic [1:0] {IDLE, PRIME, RUNNING, ERROR} state_t;

    state_t             state_reg, state_next;
    logic [NUM_CH-1:0]  mask_reg;
    logic [NUM_CH-1:0]  seen_reg;
    logic               tready_reg;
    logic               s1_valid_reg, s2_valid_reg;
    logic [15:0]        s1_data_reg;
    logic [2:0]         s1_ch_reg, s2_ch_reg;
    logic [14:0]        s2_abs_reg;
    logic [14:0]        abs_val;
    logic [15:0]        neg_val;
    logic               err_stale_reg, err_config_reg;
    logic [2:0]         stale_channel_reg;

    logic               active, keep, flush, xfer, write_en, hit_any;
    logic [2:0]         hit_idx;
    logic [NUM_CH-1:0]  write_vec, hit_vec;

    assign active   = (state_reg == PRIME) || (state_reg == RUNNING);
    assign keep     = (state_next == PRIME) || (state_next == RUNNING);
    assign flush    = active && !enable;
    assign xfer     = sample_tvalid && tready_reg;
    assign write_en = s2_valid_reg && mask_reg[s2_ch_reg] && active;
    assign neg_val  = ~s1_data_reg + 16'd1;

    // The most negative input has no positive twin, so it saturates.
    always_comb begin
        abs_val = s1_data_reg[14:0];
        if (s1_data_reg == 16'h8000)
            abs_val = 15'h7FFF;
        else if (s1_data_reg[15])
            abs_val = neg_val[14:0];
    end

    always_comb begin
        hit_any = |hit_vec;
        hit_idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit_vec[i])
                hit_idx = 3'(i);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable)
                    state_next = (channel_enable == '0) ? ERROR : PRIME;
            end
            PRIME: begin
                if (!enable)
                    state_next = IDLE;
                else if ((seen_reg & mask_reg) == mask_reg)
                    state_next = RUNNING;
            end
            RUNNING: begin
                if (!enable)
                    state_next = IDLE;
                else if (hit_any)
                    state_next = ERROR;
            end
            default: state_next = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            mask_reg          <= '0;
            seen_reg          <= '0;
            tready_reg        <= 1'b0;
            s1_valid_reg      <= 1'b0;
            s1_data_reg       <= '0;
            s1_ch_reg         <= '0;
            s2_valid_reg      <= 1'b0;
            s2_abs_reg        <= '0;
            s2_ch_reg         <= '0;
            err_stale_reg     <= 1'b0;
            err_config_reg    <= 1'b0;
            stale_channel_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tready_reg   <= active && keep;
            s1_valid_reg <= xfer && keep;
            s1_data_reg  <= sample_tdata;
            s1_ch_reg    <= sample_tchannel;
            s2_valid_reg <= s1_valid_reg && keep;
            s2_abs_reg   <= abs_val;
            s2_ch_reg    <= s1_ch_reg;
            if (state_reg == IDLE && enable) begin
                mask_reg <= channel_enable;
                if (channel_enable == '0)
                    err_config_reg <= 1'b1;
            end
            if (state_reg == IDLE || flush)
                seen_reg <= '0;
            else
                seen_reg <= seen_reg | write_vec;
            if (state_reg == RUNNING && enable && hit_any) begin
                err_stale_reg     <= 1'b1;
                stale_channel_reg <= hit_idx;
            end
        end
    end

    // Per-channel slot and staleness counter; a write on the limit edge wins.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [14:0] slot_reg;
            logic [15:0] cnt_reg;

            assign write_vec[gi] = write_en && (s2_ch_reg == 3'(gi));
            assign hit_vec[gi]   = (state_reg == RUNNING) && mask_reg[gi] &&
                                   (stale_limit != 16'd0) && !write_vec[gi] &&
                                   ((cnt_reg + 16'd1) == stale_limit);
            assign abs_sample_concat[gi*15 +: 15] = slot_reg;

            always_ff @(posedge clk) begin
                if (rst || flush)
                    slot_reg <= '0;
                else if (write_vec[gi])
                    slot_reg <= s2_abs_reg;

                if (rst || flush || state_reg != RUNNING || write_vec[gi])
                    cnt_reg <= '0;
                else
                    cnt_reg <= cnt_reg + 16'd1;
            end
        end
    endgenerate

    assign sample_tready    = tready_reg;
    assign sample_core_done = (state_reg == RUNNING);
    assign err_stale        = err_stale_reg;
    assign err_config       = err_config_reg;
    assign stale_channel    = stale_channel_reg;

endmodule

// File: tb/tb_abs_sample_collector.sv
// Directed test of abs_sample_collector: reset, abs conversion, masking,
// staleness boundary and mid-stream stop/reset.
module tb_abs_sample_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [7:0]   channel_enable;
    logic [15:0]  stale_limit;
    logic [15:0]  sample_tdata;
    logic [2:0]   sample_tchannel;
    logic         sample_tvalid;
    logic         sample_tready;
    logic [119:0] abs_sample_concat;
    logic         sample_core_done;
    logic         err_stale;
    logic         err_config;
    logic [2:0]   stale_channel;

    int n_assert = 0;
    int n_fail   = 0;

    abs_sample_collector dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .channel_enable    (channel_enable),
        .stale_limit       (stale_limit),
        .sample_tdata      (sample_tdata),
        .sample_tchannel   (sample_tchannel),
        .sample_tvalid     (sample_tvalid),
        .sample_tready     (sample_tready),
        .abs_sample_concat (abs_sample_concat),
        .sample_core_done  (sample_core_done),
        .err_stale         (err_stale),
        .err_config        (err_config),
        .stale_channel     (stale_channel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] data);
        sample_tvalid   = 1'b1;
        sample_tchannel = ch;
        sample_tdata    = data;
        $display("xfer ch=%0d data=%h tready=%0b", ch, data, sample_tready);
        step();
    endtask

    task automatic idle(input int n);
        sample_tvalid = 1'b0;
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [119:0] pack8(
        input logic [14:0] v0, input logic [14:0] v1, input logic [14:0] v2, input logic [14:0] v3,
        input logic [14:0] v4, input logic [14:0] v5, input logic [14:0] v6, input logic [14:0] v7);
        return {v7, v6, v5, v4, v3, v2, v1, v0};
    endfunction

    task automatic chk_all_clear(input string tag);
        chkv({tag, "_concat"}, abs_sample_concat, 120'd0);
        chk1({tag, "_done"}, sample_core_done, 1'b0);
        chk1({tag, "_tready"}, sample_tready, 1'b0);
        chk1({tag, "_err_stale"}, err_stale, 1'b0);
        chk1({tag, "_err_config"}, err_config, 1'b0);
        chk3({tag, "_stale_ch"}, stale_channel, 3'd0);
    endtask

    int rr;
    logic [2:0] others [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        rst = 1'b1; enable = 1'b0; channel_enable = 8'h00; stale_limit = 16'd0;
        sample_tdata = '0; sample_tchannel = '0; sample_tvalid = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all_clear("reset");
        end
        rst = 1'b0;

        // Absolute-value conversion
        channel_enable = 8'hFF; enable = 1'b1;
        step();
        chk1("abs_tready_prime_edge", sample_tready, 1'b0);
        step();
        chk1("abs_tready_up", sample_tready, 1'b1);
        send(3'd0, 16'h0005); send(3'd1, 16'hFFFB); send(3'd2, 16'h0000); send(3'd3, 16'h7FFF);
        send(3'd4, 16'h8001); send(3'd5, 16'h8000); send(3'd6, 16'hFFFF); send(3'd7, 16'h0064);
        sample_tvalid = 1'b0;
        chk1("abs_done_k", sample_core_done, 1'b0);
        step();
        chk1("abs_done_k1", sample_core_done, 1'b0);
        step();
        chk1("abs_done_k2", sample_core_done, 1'b0);
        chkv("abs_ch7_k2", abs_sample_concat,
             pack8(15'd5, 15'd5, 15'd0, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'd1, 15'd100));
        step();
        chk1("abs_done_k3", sample_core_done, 1'b1);
        enable = 1'b0;
        step();
        chk_all_clear("abs_disable");

        // Channel mask 0x05
        channel_enable = 8'h05; enable = 1'b1;
        step(); step();
        chk1("mask_tready", sample_tready, 1'b1);
        send(3'd1, 16'd77); send(3'd1, 16'd78); send(3'd1, 16'd79);
        idle(4);
        chkv("mask_ch1_dropped", abs_sample_concat, 120'd0);
        chk1("mask_no_done_a", sample_core_done, 1'b0);
        send(3'd0, 16'hFFFD);
        idle(4);
        chk1("mask_no_done_b", sample_core_done, 1'b0);
        chkv("mask_ch0", abs_sample_concat, pack8(15'd3, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0));
        send(3'd2, 16'd9);
        sample_tvalid = 1'b0;
        step(); step();
        chk1("mask_done_k2", sample_core_done, 1'b0);
        step();
        chk1("mask_done_k3", sample_core_done, 1'b1);
        chkv("mask_concat", abs_sample_concat, pack8(15'd3, 15'd0, 15'd9, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0));
        enable = 1'b0;
        step();
        channel_enable = 8'h00; enable = 1'b1;
        step();
        chk1("cfg_err", err_config, 1'b1);
        chk1("cfg_tready", sample_tready, 1'b0);
        enable = 1'b0;
        step(); step();
        chk1("cfg_sticky", err_config, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_clear("cfg_reset");

        // Staleness: limit 10, ch3 every 10 edges, the rest round-robin
        stale_limit = 16'd10; channel_enable = 8'hFF; enable = 1'b1;
        step(); step();
        rr = 0;
        for (int t = 0; t <= 204; t++) begin
            if (t % 10 == 0) begin
                if (t < 200) send(3'd3, 16'(t + 1));
                else idle(1);
            end else begin
                send(others[rr % 7], 16'hFF00);
                rr++;
            end
            if (t == 201 || t == 202 || t == 60 || t == 150 || t == 199)
                chk1($sformatf("stale_err_t%0d", t), err_stale, (t >= 202));
            else if (err_stale !== (t >= 202))
                chk1($sformatf("stale_err_t%0d", t), err_stale, (t >= 202));
            if (t == 202) begin
                chk3("stale_channel", stale_channel, 3'd3);
                chk1("stale_tready", sample_tready, 1'b0);
                chk1("stale_done", sample_core_done, 1'b0);
            end
        end
        sample_tvalid = 1'b0;
        enable = 1'b0;
        step();
        chk1("stale_sticky", err_stale, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_clear("stale_reset");

        // Mid-stream enable drop, then re-prime
        stale_limit = 16'd0; channel_enable = 8'hFF; enable = 1'b1;
        step(); step();
        for (int t = 0; t < 20; t++)
            send(3'(t % 8), 16'(t + 1));
        chk1("mid_done", sample_core_done, 1'b1);
        chkv("mid_concat", abs_sample_concat,
             pack8(15'd17, 15'd18, 15'd11, 15'd12, 15'd13, 15'd14, 15'd15, 15'd16));
        enable = 1'b0;
        send(3'd0, 16'd500);
        chk1("mid_drop_done", sample_core_done, 1'b0);
        chk1("mid_drop_tready", sample_tready, 1'b0);
        chkv("mid_drop_concat", abs_sample_concat, 120'd0);
        send(3'd1, 16'd501);
        chkv("mid_drop_flushed", abs_sample_concat, 120'd0);
        enable = 1'b1;
        step(); step();
        for (int t = 0; t < 7; t++)
            send(3'(t), 16'd2);
        idle(5);
        chk1("reprime_not_done", sample_core_done, 1'b0);
        send(3'd7, 16'd2);
        idle(3);
        chk1("reprime_done", sample_core_done, 1'b1);

        // Same stream, stopped by reset pulse
        for (int t = 0; t < 12; t++)
            send(3'(t % 8), 16'(t + 1));
        rst = 1'b1;
        send(3'd2, 16'd600);
        rst = 1'b0;
        chk_all_clear("mid_rst");
        sample_tvalid = 1'b0;
        step(); step();
        for (int t = 0; t < 7; t++)
            send(3'(t), 16'd4);
        idle(5);
        chk1("rst_reprime_not_done", sample_core_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
